alarm_buzzer_arbiter: RTL
=========================

Name: alarm_buzzer_arbiter

Overview:
- Shares the single appliance buzzer between three alarm requesters, from highest to lowest priority:
  - temperature-high warning
  - door-open warning (driven by warn_door_open from the door-warning block)
  - one-shot chime request
- Arbitrates between the requesters and sequences the beep pattern for the granted source.
- Handles user acknowledge and snooze.
- Sits between the warning generators and the buzzer driver.

Parameters:
- BEEP_ON, 4, cycles buzzer is high per beep
- BEEP_OFF, 4, cycles buzzer is low between beeps
- CHIME_BEEPS, 3, beeps per chime
- SNOOZE_CYCLES, 32, silent cycles after ack
- CNT_W, 8, width of phase/snooze counters; must hold max(BEEP_ON, BEEP_OFF, SNOOZE_CYCLES)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets at the next rising edge)
- warn_temp_high  in  1  level request, highest priority
- warn_door_open  in  1  level request, middle priority
- chime_req  in  1  single-cycle pulse request, lowest priority
- ack  in  1  single-cycle user acknowledge pulse
- buzzer  out  1  buzzer drive, registered
- alarm_src  out  2  granted source, registered: 00 none, 01 chime, 10 door, 11 temp
- busy  out  1  high in any state other than IDLE, registered

Behaviour:
- Reset:
  - Applies when reset==0 at a rising edge, including mid-pattern.
  - State goes to IDLE; buzzer=0, alarm_src=00, busy=0.
  - chime_pending, counters and snoozed_src all clear.
  - Request inputs are ignored in that cycle.
- Timing: inputs are sampled at edge k. New state and outputs are visible after edge k. Latency is 1 cycle, with no combinational input-to-output path.
- chime_pending flag:
  - Set by chime_req in any state.
  - Depth 1: extra requests while the flag is set are dropped.
  - Cleared when CHIME is granted.
- State IDLE: each cycle, go to TEMP if warn_temp_high, else DOOR if warn_door_open, else CHIME if chime_pending (or chime_req this cycle), else stay.
- State TEMP:
  - buzzer=1 continuously, alarm_src=11.
  - warn_temp_high low -> IDLE.
  - ack -> SNOOZE with snoozed_src=temp.
- State DOOR:
  - Beep pattern: buzzer high BEEP_ON cycles, then low BEEP_OFF cycles, repeating. The first cycle after entry is ON.
  - alarm_src=10.
  - warn_temp_high -> TEMP (preempts).
  - warn_door_open low -> IDLE.
  - ack -> SNOOZE with snoozed_src=door.
- State CHIME:
  - Plays CHIME_BEEPS on/off periods, then -> IDLE. The final OFF period is included.
  - alarm_src=01.
  - warn_temp_high -> TEMP and warn_door_open -> DOOR (both preempt). The preempted chime re-sets chime_pending and replays from beep 0 later.
  - ack cancels the chime -> IDLE, with no replay.
- State SNOOZE:
  - buzzer=0, alarm_src=00, busy=1.
  - Counts SNOOZE_CYCLES cycles, then -> IDLE and re-arbitrates.
  - If snoozed_src=door and warn_temp_high rises -> TEMP immediately.
  - If snoozed_src=temp, no source preempts.
  - ack in SNOOZE is ignored.
- Priority on simultaneous events:
  - reset beats everything.
  - warn_temp_high beats ack in DOOR/CHIME; the result is TEMP and the ack is discarded.
  - ack beats source deassertion in the same cycle; the result is SNOOZE.
  - chime_req together with ack in CHIME: the current chime is cancelled and the new request sets pending -> replay.
- ack in IDLE is ignored.
- Pattern counters restart on every state entry.
- Counters saturate, never wrap.

Test Plan:
1. Reset hold: reset=0 for 5 cycles with all requests high -> buzzer=0, alarm_src=00, busy=0 throughout. After reset=1 -> alarm_src=11 one cycle later.
2. Door pattern: warn_door_open=1 for 20 cycles -> alarm_src=10 and buzzer sequence 1111 0000 1111 0000 1111. Drop the door input -> IDLE and buzzer=0 next cycle.
3. Chime: single chime_req pulse -> buzzer 3×(4 high, 4 low), 24 cycles total, then alarm_src=00, busy=0. A second chime_req mid-chime -> exactly one replay.
4. Preemption: door active, warn_temp_high asserted at door cycle 2 -> next cycle buzzer=1 steady, alarm_src=11. Drop temp while door still high -> DOOR restarts at ON phase.
5. Snooze: ack in DOOR -> buzzer=0, alarm_src=00, busy=1 for 32 cycles, then DOOR resumes if the door is still open. Temp rise at snooze cycle 10 -> TEMP on the next cycle.
6. Mid-operation reset: reset=0 during chime beep 2 with chime_pending set -> all outputs 0 and pending cleared. No chime after reset=1.

Source files
------------

// File: rtl/alarm_buzzer_arbiter.sv
// rtl/alarm_buzzer_arbiter.sv - shares one buzzer between temp, door and chime alarms
module alarm_buzzer_arbiter #(
  parameter int BEEP_ON       = 4,
  parameter int BEEP_OFF      = 4,
  parameter int CHIME_BEEPS   = 3,
  parameter int SNOOZE_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       warn_temp_high,
  input  logic       warn_door_open,
  input  logic       chime_req,
  input  logic       ack,
  output logic       buzzer,
  output logic [1:0] alarm_src,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TEMP   = 3'd1;
  localparam logic [2:0] S_DOOR   = 3'd2;
  localparam logic [2:0] S_CHIME  = 3'd3;
  localparam logic [2:0] S_SNOOZE = 3'd4;

  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ON_LEN     = CNT_W'(BEEP_ON);
  localparam logic [CNT_W-1:0] OFF_LEN    = CNT_W'(BEEP_OFF);
  localparam logic [CNT_W-1:0] LAST_BEEP  = CNT_W'(CHIME_BEEPS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LEN = CNT_W'(SNOOZE_CYCLES);

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_n;
  logic [CNT_W-1:0] beep_cnt, beep_cnt_n;
  logic [CNT_W-1:0] snooze_cnt, snooze_cnt_n;
  logic             phase_on, phase_on_n;
  logic             snoozed_door, snoozed_door_n;
  logic             chime_pending, chime_pending_n;
  logic             buzzer_n, busy_n;
  logic [1:0]       alarm_src_n;
  logic             phase_done, last_beep;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  assign phase_done = phase_on ? (phase_cnt >= ON_LEN) : (phase_cnt >= OFF_LEN);
  assign last_beep  = (beep_cnt >= LAST_BEEP);

  // Next-state, pattern sequencing and next registered outputs
  always_comb begin
    state_n         = state;
    phase_on_n      = phase_on;
    phase_cnt_n     = phase_cnt;
    beep_cnt_n      = beep_cnt;
    snooze_cnt_n    = snooze_cnt;
    snoozed_door_n  = snoozed_door;
    chime_pending_n = chime_pending | chime_req;

    case (state)
      S_IDLE: begin
        if (warn_temp_high) begin
          state_n = S_TEMP;
        end else if (warn_door_open) begin
          state_n = S_DOOR;
        end else if (chime_pending || chime_req) begin
          state_n         = S_CHIME;
          chime_pending_n = 1'b0;
        end
      end
      S_TEMP: begin
        if (ack) begin
          state_n        = S_SNOOZE;
          snoozed_door_n = 1'b0;
        end else if (!warn_temp_high) begin
          state_n = S_IDLE;
        end
      end
      S_DOOR: begin
        if (warn_temp_high) begin
          state_n = S_TEMP;
        end else if (ack) begin
          state_n        = S_SNOOZE;
          snoozed_door_n = 1'b1;
        end else if (!warn_door_open) begin
          state_n = S_IDLE;
        end else if (phase_done) begin
          phase_on_n  = !phase_on;
          phase_cnt_n = ONE;
        end else begin
          phase_cnt_n = sat_inc(phase_cnt);
        end
      end
      S_CHIME: begin
        // A preempted chime goes back in the queue; an acknowledged one does not
        if (warn_temp_high) begin
          state_n         = S_TEMP;
          chime_pending_n = 1'b1;
        end else if (warn_door_open) begin
          state_n         = S_DOOR;
          chime_pending_n = 1'b1;
        end else if (ack) begin
          state_n = S_IDLE;
        end else if (phase_done && !phase_on && last_beep) begin
          state_n = S_IDLE;
        end else if (phase_done) begin
          phase_on_n  = !phase_on;
          phase_cnt_n = ONE;
          if (!phase_on) begin
            beep_cnt_n = sat_inc(beep_cnt);
          end
        end else begin
          phase_cnt_n = sat_inc(phase_cnt);
        end
      end
      S_SNOOZE: begin
        if (snoozed_door && warn_temp_high) begin
          state_n = S_TEMP;
        end else if (snooze_cnt >= SNOOZE_LEN) begin
          state_n = S_IDLE;
        end else begin
          snooze_cnt_n = sat_inc(snooze_cnt);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Every state entry restarts the pattern at the first ON cycle
    if (state_n != state) begin
      phase_on_n   = 1'b1;
      phase_cnt_n  = ONE;
      beep_cnt_n   = '0;
      snooze_cnt_n = ONE;
    end

    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_TEMP:  begin alarm_src_n = 2'b11; buzzer_n = 1'b1;       end
      S_DOOR:  begin alarm_src_n = 2'b10; buzzer_n = phase_on_n; end
      S_CHIME: begin alarm_src_n = 2'b01; buzzer_n = phase_on_n; end
      default: begin alarm_src_n = 2'b00; buzzer_n = 1'b0;       end
    endcase
  end

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      phase_on      <= 1'b0;
      phase_cnt     <= '0;
      beep_cnt      <= '0;
      snooze_cnt    <= '0;
      snoozed_door  <= 1'b0;
      chime_pending <= 1'b0;
      buzzer        <= 1'b0;
      alarm_src     <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      phase_on      <= phase_on_n;
      phase_cnt     <= phase_cnt_n;
      beep_cnt      <= beep_cnt_n;
      snooze_cnt    <= snooze_cnt_n;
      snoozed_door  <= snoozed_door_n;
      chime_pending <= chime_pending_n;
      buzzer        <= buzzer_n;
      alarm_src     <= alarm_src_n;
      busy          <= busy_n;
    end
  end

endmodule
